// File: rtl/bsg_blackparrot_mc_sched_pkg.sv
// Shared types for the BlackParrot manycore link scheduler.
package bsg_blackparrot_mc_sched_pkg;

  typedef enum logic [1:0] {eRun, eDrain, eDone} mc_sched_state_e;

endpackage

// File: rtl/bsg_blackparrot_mc_credit_counter.sv
// Per-link outstanding-request counter: +1 on issue, -1 on credit return.
module bsg_blackparrot_mc_credit_counter
  import bsg_blackparrot_mc_sched_pkg::*;
#(
  parameter int credits_p = 16,
  parameter int cw_p      = $clog2(credits_p+1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [cw_p-1:0] cnt_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [cw_p-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i)
      cnt_d = cnt_q + cw_p'(1);
    else if (dec_i && !inc_i && cnt_q != '0)
      cnt_d = cnt_q - cw_p'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // A return with nothing outstanding means the two sides are out of sync.
  always_ff @(posedge clk_i) begin
    if (!reset_i)
      assert (!(dec_i && !inc_i && cnt_q == '0))
        else $error("credit underflow");
  end

  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == cw_p'(credits_p));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/bsg_blackparrot_mc_link_scheduler.sv
// Round-robin dispatch of tile request packets onto per-row proc links, with
// per-link credit tracking and a drain fence.
module bsg_blackparrot_mc_link_scheduler
  import bsg_blackparrot_mc_sched_pkg::*;
#(
  parameter int num_links_p    = 4,
  parameter int packet_width_p = 128,
  parameter int credits_p      = 16,
  parameter int cw_lp          = $clog2(credits_p+1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [packet_width_p-1:0]     pkt_i,
  input  logic                          pkt_v_i,
  output logic                          pkt_ready_o,
  output logic [packet_width_p-1:0]     link_pkt_o,
  output logic [num_links_p-1:0]        link_v_o,
  input  logic [num_links_p-1:0]        link_ready_i,
  input  logic [num_links_p-1:0]        credit_return_i,
  input  logic                          fence_i,
  output logic                          fence_done_o,
  output logic [num_links_p*cw_lp-1:0]  credits_used_o
);

  localparam int pw_lp = (num_links_p > 1) ? $clog2(num_links_p) : 1;

  mc_sched_state_e                   state_q;
  logic [pw_lp-1:0]                  rr_q, rr_d, grant;
  logic [num_links_p-1:0][cw_lp-1:0] cnt;
  logic [num_links_p-1:0]            full, empty, elig, xfer_v;
  logic                              found, xfer;

  for (genvar i = 0; i < num_links_p; i++) begin : g_cnt
    bsg_blackparrot_mc_credit_counter #(.credits_p(credits_p), .cw_p(cw_lp)) u_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (xfer_v[i]),
      .dec_i   (credit_return_i[i]),
      .cnt_o   (cnt[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  // Uses the registered count, so a same-cycle return never unblocks a full link.
  assign elig = link_ready_i & ~full;

  // Rotate-priority pick: first eligible link at or above rr_q, wrapping.
  always_comb begin
    grant = rr_q;
    found = 1'b0;
    for (int k = 0; k < num_links_p; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % num_links_p;
      if (!found && elig[idx]) begin
        grant = pw_lp'(idx);
        found = 1'b1;
      end
    end
  end

  assign pkt_ready_o = (state_q == eRun) & ~fence_i & ~reset_i & (|elig);
  assign xfer        = pkt_v_i & pkt_ready_o;
  assign xfer_v      = xfer ? (num_links_p'(1) << grant) : '0;
  assign link_v_o    = xfer_v;
  assign link_pkt_o  = pkt_i;
  assign rr_d        = xfer ? pw_lp'((int'(grant) + 1) % num_links_p) : rr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eRun;
      rr_q    <= '0;
    end else begin
      rr_q <= rr_d;
      case (state_q)
        eRun:    if (fence_i) state_q <= eDrain;
        eDrain:  if (!fence_i) state_q <= eRun;
                 else if (&empty) state_q <= eDone;
        eDone:   if (!fence_i) state_q <= eRun;
        default: state_q <= eRun;
      endcase
    end
  end

  assign fence_done_o   = (state_q == eDone);
  assign credits_used_o = cnt;

endmodule

// File: tb/tb_bsg_blackparrot_mc_link_scheduler.sv
// Directed bench for the manycore link scheduler: vector table plus fence/reset sequences.
module tb_bsg_blackparrot_mc_link_scheduler;
  localparam int NL = 4, PW = 128, CR = 16, CW = 5;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [PW-1:0] pkt_i;
  logic          pkt_v_i, pkt_ready_o, fence_i, fence_done_o;
  logic [PW-1:0] link_pkt_o;
  logic [NL-1:0] link_v_o, link_ready_i, credit_return_i;
  logic [NL*CW-1:0] credits_used_o;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  bsg_blackparrot_mc_link_scheduler #(.num_links_p(NL), .packet_width_p(PW), .credits_p(CR)) dut (
    .clk_i(clk), .reset_i(reset_i), .pkt_i(pkt_i), .pkt_v_i(pkt_v_i), .pkt_ready_o(pkt_ready_o),
    .link_pkt_o(link_pkt_o), .link_v_o(link_v_o), .link_ready_i(link_ready_i),
    .credit_return_i(credit_return_i), .fence_i(fence_i), .fence_done_o(fence_done_o),
    .credits_used_o(credits_used_o)
  );

  typedef struct {
    logic [3:0] rdy, ret;
    logic       v, fence, exp_pr;
    logic [3:0] exp_lv;
    logic       exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int l, input int exp);
    logic [CW-1:0] c;
    c = credits_used_o[l*CW +: CW];
    chk(name, 128'(c), 128'(exp));
  endtask

  // Drive one cycle of inputs after a negedge, compare outputs before the next posedge.
  task automatic step(input string name, input logic [3:0] rdy, input logic [3:0] ret,
                      input logic v, input logic fence, input logic exp_pr,
                      input logic [3:0] exp_lv, input logic exp_done);
    @(negedge clk);
    link_ready_i = rdy; credit_return_i = ret; pkt_v_i = v; fence_i = fence;
    pkt_i = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk({name, ".ready"}, 128'(pkt_ready_o), 128'(exp_pr));
    chk({name, ".link_v"}, 128'(link_v_o), 128'(exp_lv));
    chk({name, ".done"}, 128'(fence_done_o), 128'(exp_done));
  endtask

  vec_t tbl[8];

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{rdy: 4'b1111, ret: 4'b0, v: 1'b1, fence: 1'b0, exp_pr: 1'b1,
                 exp_lv: 4'(1 << (i % 4)), exp_done: 1'b0};

    reset_i = 1'b1; pkt_i = '0; pkt_v_i = 1'b0; fence_i = 1'b0;
    link_ready_i = '0; credit_return_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    link_ready_i = 4'b1111; pkt_v_i = 1'b1; #1;
    chk("rst.ready", 128'(pkt_ready_o), 128'(0));
    chk("rst.link_v", 128'(link_v_o), 128'(0));
    chk("rst.done", 128'(fence_done_o), 128'(0));
    chk("rst.credits", 128'(credits_used_o), 128'(0));
    pkt_v_i = 1'b0; reset_i = 1'b0;

    // 1: round-robin across all ready links
    for (int i = 0; i < 8; i++)
      step($sformatf("rr%0d", i), tbl[i].rdy, tbl[i].ret, tbl[i].v, tbl[i].fence,
           tbl[i].exp_pr, tbl[i].exp_lv, tbl[i].exp_done);
    chk("pkt_wire", link_pkt_o, pkt_i);
    step("rr_idle", 4'b0, 4'b0, 0, 0, 0, 4'b0, 0);
    for (int l = 0; l < NL; l++) chk_cnt($sformatf("rr_cnt%0d", l), l, 2);
    step("ret_a", 4'b0, 4'b1111, 0, 0, 0, 4'b0, 0);
    step("ret_b", 4'b0, 4'b1111, 0, 0, 0, 4'b0, 0);
    step("ret_c", 4'b0, 4'b0, 0, 0, 0, 4'b0, 0);
    chk("ret_zero", 128'(credits_used_o), 128'(0));

    // 2: skip non-ready link 2 and wrap to link 0
    step("w0", 4'b1111, 4'b0, 1, 0, 1, 4'b0001, 0);
    step("w1", 4'b1111, 4'b0, 1, 0, 1, 4'b0010, 0);
    step("w2", 4'b1011, 4'b0, 1, 0, 1, 4'b1000, 0);
    step("w3", 4'b1011, 4'b0, 1, 0, 1, 4'b0001, 0);
    step("w4", 4'b0, 4'b1011, 0, 0, 0, 4'b0, 0);
    step("w5", 4'b0, 4'b0001, 0, 0, 0, 4'b0, 0);
    step("w6", 4'b0, 4'b0, 0, 0, 0, 4'b0, 0);
    chk("w_zero", 128'(credits_used_o), 128'(0));

    // 3: fill link 0 to credits_p; same-cycle return must not unblock
    for (int i = 0; i < CR; i++) step($sformatf("f%0d", i), 4'b0001, 4'b0, 1, 0, 1, 4'b0001, 0);
    step("full", 4'b0001, 4'b0, 1, 0, 0, 4'b0, 0);
    chk_cnt("full_cnt", 0, 16);
    step("full_ret", 4'b0001, 4'b0001, 1, 0, 0, 4'b0, 0);
    step("unfull", 4'b0001, 4'b0, 0, 0, 1, 4'b0, 0);
    chk_cnt("unfull_cnt", 0, 15);
    for (int i = 0; i < 15; i++) step("f_ret", 4'b0, 4'b0001, 0, 0, 0, 4'b0, 0);

    // 4: simultaneous issue and return at cnt=5
    for (int i = 0; i < 5; i++) step("s_fill", 4'b0010, 4'b0, 1, 0, 1, 4'b0010, 0);
    step("s_both", 4'b0010, 4'b0010, 1, 0, 1, 4'b0010, 0);
    step("s_chk", 4'b0, 4'b0, 0, 0, 0, 4'b0, 0);
    chk_cnt("s_cnt", 1, 5);
    for (int i = 0; i < 5; i++) step("s_ret", 4'b0, 4'b0010, 0, 0, 0, 4'b0, 0);

    // 5: fence drains three outstanding on link 2
    for (int i = 0; i < 3; i++) step("d_fill", 4'b0100, 4'b0, 1, 0, 1, 4'b0100, 0);
    step("d_fence", 4'b0100, 4'b0, 1, 1, 0, 4'b0, 0);
    for (int i = 0; i < 3; i++) step("d_ret", 4'b0100, 4'b0100, 1, 1, 0, 4'b0, 0);
    step("d_zero", 4'b0100, 4'b0, 1, 1, 0, 4'b0, 0);
    step("d_done", 4'b0100, 4'b0, 1, 1, 0, 4'b0, 1);
    step("d_drop", 4'b1111, 4'b0, 1, 0, 0, 4'b0, 1);
    step("d_resume", 4'b1111, 4'b0, 1, 0, 1, 4'b1000, 0);
    step("d_ret3", 4'b0, 4'b1000, 0, 0, 0, 4'b0, 0);

    // 6: fence with nothing outstanding, then reset while draining
    step("z0", 4'b0, 4'b0, 0, 1, 0, 4'b0, 0);
    step("z1", 4'b0, 4'b0, 0, 1, 0, 4'b0, 0);
    step("z2", 4'b0, 4'b0, 0, 1, 0, 4'b0, 1);
    step("z3", 4'b0, 4'b0, 0, 0, 0, 4'b0, 1);
    step("z4", 4'b1111, 4'b0, 1, 0, 1, 4'b0001, 0);
    step("z5", 4'b1111, 4'b0, 1, 0, 1, 4'b0010, 0);
    step("z6", 4'b1111, 4'b0, 1, 1, 0, 4'b0, 0);
    @(negedge clk);
    reset_i = 1'b1; pkt_v_i = 1'b1; link_ready_i = 4'b1111; fence_i = 1'b1; #1;
    chk("zr.ready", 128'(pkt_ready_o), 128'(0));
    chk("zr.link_v", 128'(link_v_o), 128'(0));
    @(negedge clk);
    reset_i = 1'b0; pkt_v_i = 1'b0; fence_i = 1'b0; #1;
    chk("zr.credits", 128'(credits_used_o), 128'(0));
    chk("zr.done", 128'(fence_done_o), 128'(0));
    chk("zr.run", 128'(pkt_ready_o), 128'(1));
    step("zr.rr", 4'b1111, 4'b0, 1, 0, 1, 4'b0001, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
